// File: rtl/led_pwm_lbus_pkg.sv
// Shared types for the LED brightness stage: local-bus request, address
// decode helpers, mode encoding and register offsets.
package led_pwm_lbus_pkg;

  // Local-bus slave request as seen by every peripheral on the bus.
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } lb_slave_t;

  // Brightness mode held in CTRL[2:1]; encoding 3 behaves like STATIC.
  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_PWM      = 2'd1,
    MODE_BREATHE  = 2'd2,
    MODE_STATIC_3 = 2'd3
  } led_pwm_mode_e;

  // Breathe direction; DOWN reads back as dir=1 in STATUS.
  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breathe_state_e;

  localparam logic [7:0] LED_PWM_CTRL     = 8'd0;
  localparam logic [7:0] LED_PWM_DUTY     = 8'd1;
  localparam logic [7:0] LED_PWM_PRESCALE = 8'd2;
  localparam logic [7:0] LED_PWM_STATUS   = 8'd3;

  function automatic logic MatchWLB(input lb_slave_t lb, input logic [7:0] a);
    return lb.wr && (lb.addr == a);
  endfunction

  function automatic logic MatchRLB(input lb_slave_t lb, input logic [7:0] a);
    return lb.rd && (lb.addr == a);
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Waveform engine: prescaler, 8-bit PWM counter and the breathe level
// ramp. Produces the shared pwm_on gate plus breathe level/direction.
module led_pwm_core
  import led_pwm_lbus_pkg::*;
#(
  parameter logic [7:0] STEP = 8'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  led_pwm_mode_e mode,
  input  logic [7:0]    duty,
  input  logic [15:0]   prescale,
  input  logic          clr,
  input  logic          pre_clr,
  output logic          pwm_on,
  output logic [7:0]    level,
  output logic          dir
);

  breathe_state_e state, state_nx;
  logic [15:0] pre_cnt, pre_cnt_nx;
  logic [7:0]  pwm_cnt, pwm_cnt_nx;
  logic [7:0]  level_nx;
  logic        tick;
  logic        period_end;
  logic [7:0]  duty_sel;

  // Ramp up, saturating at full scale instead of wrapping.
  function automatic logic [7:0] sat_up(input logic [7:0] lv);
    logic [8:0] s;
    s = {1'b0, lv} + {1'b0, STEP};
    return (s >= 9'd255) ? 8'hFF : s[7:0];
  endfunction

  // Ramp down, saturating at zero instead of wrapping.
  function automatic logic [7:0] sat_dn(input logic [7:0] lv);
    return (lv <= STEP) ? 8'h00 : (lv - STEP);
  endfunction

  // Next-state logic for counters and breathe FSM; control clears win last.
  always_comb begin
    tick       = (pre_cnt == prescale);
    period_end = tick && (pwm_cnt == 8'hFF);
    pre_cnt_nx = tick ? 16'd0 : (pre_cnt + 16'd1);
    pwm_cnt_nx = tick ? (pwm_cnt + 8'd1) : pwm_cnt;
    level_nx   = level;
    state_nx   = state;
    if (period_end && (mode == MODE_BREATHE)) begin
      case (state)
        BR_UP: begin
          level_nx = sat_up(level);
          if (level_nx == 8'hFF) state_nx = BR_DOWN;
        end
        default: begin
          level_nx = sat_dn(level);
          if (level_nx == 8'h00) state_nx = BR_UP;
        end
      endcase
    end
    if (pre_clr) pre_cnt_nx = 16'd0;
    if (clr || !en) begin
      pre_cnt_nx = 16'd0;
      pwm_cnt_nx = 8'd0;
      level_nx   = 8'd0;
      state_nx   = BR_UP;
    end
  end

  // State register for prescaler, PWM counter, level and direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= 16'd0;
      pwm_cnt <= 8'd0;
      level   <= 8'd0;
      state   <= BR_UP;
    end else begin
      pre_cnt <= pre_cnt_nx;
      pwm_cnt <= pwm_cnt_nx;
      level   <= level_nx;
      state   <= state_nx;
    end
  end

  assign duty_sel = (mode == MODE_BREATHE) ? level : duty;
  assign pwm_on   = (pwm_cnt < duty_sel);
  assign dir      = (state == BR_DOWN);

endmodule

// File: rtl/led_pwm_lbus.sv
// LED brightness/breathe stage: local-bus registers, readback mux and the
// registered output that gates lit (active-low) LEDs with the PWM wave.
module led_pwm_lbus
  import led_pwm_lbus_pkg::*;
#(
  parameter int         LED_NUM   = 8,
  parameter logic [7:0] BASE_ADDR = 8'd21,
  parameter logic [7:0] STEP      = 8'd4
) (
  input  logic               lb_clk,
  input  logic               rst_n,
  input  lb_slave_t          xt_lb,
  input  logic [LED_NUM-1:0] led_in,
  output logic [15:0]        rdata,
  output logic [LED_NUM-1:0] led_out
);

  localparam logic [7:0] A_CTRL     = BASE_ADDR + LED_PWM_CTRL;
  localparam logic [7:0] A_DUTY     = BASE_ADDR + LED_PWM_DUTY;
  localparam logic [7:0] A_PRESCALE = BASE_ADDR + LED_PWM_PRESCALE;
  localparam logic [7:0] A_STATUS   = BASE_ADDR + LED_PWM_STATUS;

  logic          en;
  led_pwm_mode_e mode;
  logic [7:0]    duty;
  logic [15:0]   prescale;
  logic          wr_ctrl, wr_duty, wr_pre;
  logic          ctrl_chg;
  logic          pwm_on;
  logic [7:0]    level;
  logic          dir;
  logic          gate_act;
  logic [LED_NUM-1:0] led_p0;
  logic [LED_NUM-1:0] led_out_p1;

  assign wr_ctrl  = MatchWLB(xt_lb, A_CTRL);
  assign wr_duty  = MatchWLB(xt_lb, A_DUTY);
  assign wr_pre   = MatchWLB(xt_lb, A_PRESCALE);
  // Only a real change of en/mode restarts the waveform.
  assign ctrl_chg = wr_ctrl &&
                    ((xt_lb.wdata[0] != en) || (xt_lb.wdata[2:1] != mode));

  // Control register file, written from the local bus.
  always_ff @(posedge lb_clk) begin
    if (!rst_n) begin
      en       <= 1'b0;
      mode     <= MODE_STATIC;
      duty     <= 8'hFF;
      prescale <= 16'd0;
    end else begin
      if (wr_ctrl) begin
        en   <= xt_lb.wdata[0];
        mode <= led_pwm_mode_e'(xt_lb.wdata[2:1]);
      end
      if (wr_duty) duty     <= xt_lb.wdata[7:0];
      if (wr_pre)  prescale <= xt_lb.wdata;
    end
  end

  led_pwm_core #(.STEP(STEP)) u_core (
    .clk      (lb_clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .duty     (duty),
    .prescale (prescale),
    .clr      (ctrl_chg),
    .pre_clr  (wr_pre),
    .pwm_on   (pwm_on),
    .level    (level),
    .dir      (dir)
  );

  // Combinational readback, zero when no register is addressed.
  always_comb begin
    rdata = 16'd0;
    if (MatchRLB(xt_lb, A_CTRL))     rdata = {13'd0, mode, en};
    if (MatchRLB(xt_lb, A_DUTY))     rdata = {8'd0, duty};
    if (MatchRLB(xt_lb, A_PRESCALE)) rdata = prescale;
    if (MatchRLB(xt_lb, A_STATUS))   rdata = {7'd0, dir, level};
  end

  // p0: gate lit bits off while the PWM wave is low
  assign gate_act = en && ((mode == MODE_PWM) || (mode == MODE_BREATHE));
  assign led_p0   = gate_act ? (led_in | {LED_NUM{~pwm_on}}) : led_in;

  // p1: registered pin drive, all LEDs off in reset.
  always_ff @(posedge lb_clk) begin
    if (!rst_n) led_out_p1 <= '1;
    else        led_out_p1 <= led_p0;
  end

  assign led_out = led_out_p1;

endmodule
